// File: rtl/txbuf_reader_if.sv
// Port-A read stream bundle between the transmit-buffer reader, its RAM port A and the transmitter.
// Command, RAM port A and byte-stream signals travel together so the bench and top level wire one bundle.
interface txbuf_reader_if #(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int RAM_DATA_WIDTH = 8
);
  logic                      in_start;
  logic                      in_abort;
  logic [RAM_ADDR_WIDTH-1:0] in_base_addr;
  logic [RAM_ADDR_WIDTH:0]   in_length;
  logic [RAM_ADDR_WIDTH-1:0] out_ram_addr;
  logic                      out_ram_wr;
  logic [RAM_DATA_WIDTH-1:0] in_ram_data;
  logic [RAM_DATA_WIDTH-1:0] out_data;
  logic                      out_valid;
  logic                      in_ready;
  logic                      out_busy;
  logic                      out_done;

  modport master (
    output in_start, in_abort, in_base_addr, in_length, in_ram_data, in_ready,
    input  out_ram_addr, out_ram_wr, out_data, out_valid, out_busy, out_done
  );

  modport slave (
    input  in_start, in_abort, in_base_addr, in_length, in_ram_data, in_ready,
    output out_ram_addr, out_ram_wr, out_data, out_valid, out_busy, out_done
  );
endinterface

// File: rtl/txbuf_reader.sv
// Transmit-buffer read engine: fetches a block of bytes over RAM port A (1-cycle read latency)
// and hands them one at a time to a valid/ready byte stream.
module txbuf_reader #(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int RAM_DATA_WIDTH = 8
) (
  input  logic           in_clk,
  input  logic           in_rst,
  txbuf_reader_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, SEND} state_t;

  localparam logic [RAM_ADDR_WIDTH:0] MAX_LEN  = {1'b1, {RAM_ADDR_WIDTH{1'b0}}};
  localparam logic [RAM_ADDR_WIDTH:0] LAST_ONE = {{RAM_ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                    state;
  logic [RAM_ADDR_WIDTH-1:0] addr_p0;
  logic [RAM_ADDR_WIDTH:0]   count_p0;
  logic [RAM_DATA_WIDTH-1:0] data_p1;
  logic                      vld_p1;
  logic                      busy;
  logic                      done;

  // A block can never exceed the addressable RAM.
  function automatic logic [RAM_ADDR_WIDTH:0] sat_len(input logic [RAM_ADDR_WIDTH:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state    <= IDLE;
      addr_p0  <= '0;
      count_p0 <= '0;
      data_p1  <= '0;
      vld_p1   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.in_abort && state != IDLE) begin
        state  <= IDLE;
        vld_p1 <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.in_start && !bus.in_abort) begin
              if (bus.in_length != '0) begin
                addr_p0  <= bus.in_base_addr;
                count_p0 <= sat_len(bus.in_length);
                busy     <= 1'b1;
                state    <= FETCH;
              end else begin
                done <= 1'b1;
              end
            end
          end
          // Address stage: RAM samples addr_p0 at the end of this cycle.
          FETCH: state <= LATCH;
          // Data stage: RAM output is valid now and is registered onto the stream.
          LATCH: begin
            data_p1 <= bus.in_ram_data;
            vld_p1  <= 1'b1;
            state   <= SEND;
          end
          SEND: begin
            if (bus.in_ready) begin
              vld_p1   <= 1'b0;
              count_p0 <= count_p0 - 1'b1;
              addr_p0  <= addr_p0 + 1'b1;
              if (count_p0 == LAST_ONE) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                state <= FETCH;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.out_ram_addr = addr_p0;
  assign bus.out_ram_wr   = 1'b0;
  assign bus.out_data     = data_p1;
  assign bus.out_valid    = vld_p1;
  assign bus.out_busy     = busy;
  assign bus.out_done     = done;

endmodule

// File: doc/txbuf_reader.md
Name: txbuf_reader

Overview:
- Read-side engine for the dual-port RAM transmit buffer; the companion writer fills the buffer through port B.
- On a start command it reads a block of bytes through port A and presents them one at a time on a valid/ready byte stream toward the transmitter.
- Port A is driven read-only. This block's out_ram_wr is tied low and the RAM's port A write-data input is tied off.

Parameters:
- RAM_ADDR_WIDTH, 8: width of the RAM address, in_base_addr and out_ram_addr.
- RAM_DATA_WIDTH, 8: width of the RAM data and of the stream data.

Ports:
- in_clk  input  1  system clock; all registers update on its rising edge.
- in_rst  input  1  reset; asynchronous, active-high.
- in_start  input  1  one-cycle start request; accepted only in IDLE.
- in_abort  input  1  cancels the transfer in progress.
- in_base_addr  input  RAM_ADDR_WIDTH  first address to read; sampled when start is accepted.
- in_length  input  RAM_ADDR_WIDTH+1  number of bytes to read; sampled when start is accepted.
- out_ram_addr  output  RAM_ADDR_WIDTH  connects to the RAM port A address.
- out_ram_wr  output  1  connects to the RAM port A write enable; constant 0.
- in_ram_data  input  RAM_DATA_WIDTH  RAM port A read data.
- out_data  output  RAM_DATA_WIDTH  stream data.
- out_valid  output  1  stream data valid.
- in_ready  input  1  downstream accepts the current byte.
- out_busy  output  1  high whenever the FSM is not in IDLE.
- out_done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset values (asynchronous): state IDLE, out_ram_addr=0, out_data=0, out_valid=0, out_busy=0, out_done=0, remaining count=0.
- RAM read timing: the RAM samples its address at a rising edge, and the data is valid on in_ram_data after that edge. Read latency is 1 cycle.
- IDLE:
  - in_start=1 with in_length>0: latch in_base_addr into the address register, which drives out_ram_addr. Latch in_length into the count register, saturated to 2^RAM_ADDR_WIDTH. Go to FETCH.
  - in_start=1 with in_length=0: pulse out_done in the next cycle and stay in IDLE.
- FETCH (1 cycle): out_ram_addr holds the current address; the RAM samples it at the end of this cycle. Go to LATCH.
- LATCH (1 cycle): capture in_ram_data into out_data at the end of the cycle, set out_valid=1, go to SEND.
- SEND:
  - out_valid=1 and out_data are held stable until in_ready=1 is sampled at a rising edge; that edge is the handshake.
  - On the handshake: out_valid<=0, count decrements, and the address increments modulo 2^RAM_ADDR_WIDTH (0xFF wraps to 0x00).
  - If the count was 1, pulse out_done in the next cycle and go to IDLE; otherwise go to FETCH.
- Throughput: 3 cycles per byte when in_ready is held high. The first out_valid rises 2 cycles after the start edge.
- out_valid must never drop before its handshake, and out_data must never change while out_valid=1.
- in_start is ignored while out_busy=1.
- in_abort has priority over everything else. In any non-IDLE state it sends the FSM to IDLE at the next edge with out_valid=0 and no out_done pulse. In IDLE it is a no-op. If in_abort and in_start arrive together in IDLE, the start is ignored.
- out_ram_addr keeps its last value while in IDLE.
- Reset asserted mid-transfer returns the block immediately to its reset values; no out_done pulse.
- RAM data only on in_ram_data drives out_data; there is no combinational path from in_ram_data to any output.

Test Plan:
- Preload RAM[0x10..0x13]=0x00,0x01,0x02,0x03 through port B; start with base=0x10, length=4, in_ready=1 -> out_data sequence 00,01,02,03 at 3-cycle spacing; one out_done pulse after the 4th handshake; out_busy falls with it.
- Same preload, with in_ready low for 5 cycles on byte 0x02 -> out_valid and out_data=0x02 held for all 5 cycles; no byte lost or duplicated; total bytes = 4.
- RAM[0xFE]=0xAA, RAM[0xFF]=0x55, RAM[0x00]=0x33; base=0xFE, length=3 -> bytes AA,55,33; out_ram_addr wraps 0xFF->0x00.
- Start with length=0 -> out_done pulses one cycle later; out_busy and out_valid stay 0. Then pulse in_start again during a length=4 transfer -> the second start is ignored and exactly 4 bytes are sent.
- Abort during SEND of the 2nd byte -> next edge: IDLE, out_valid=0, no out_done; a new start with base=0x10, length=1 then delivers 0x00 normally.
- Assert in_rst asynchronously between clock edges mid-transfer -> all outputs reach reset values immediately; after release the block stays idle until in_start.
